// File: rtl/tiled_conv_mac_seq.sv
// tiled_conv_mac_seq
//   Sequencer for the shared 16x16 multiplier of the tiled convolution
//   datapath. Each accepted start streams `len` weight/feature pairs out of
//   two single-port buffers (1-cycle read latency), routes them through the
//   external combinational multiplier and accumulates the 28-bit products.
//   The sum is returned with the ap_ctrl_hs handshake.
//
// Ports
//   ap_clk, ap_rst           clock, synchronous active-high reset
//   ap_start/done/idle/ready ap_ctrl_hs handshake (ap_ready == ap_done)
//   len, base_w, base_x      job descriptor, latched when a start is accepted
//   w_address0/ce0, w_q0     weight buffer read port (signed 16-bit data)
//   x_address0/ce0, x_q0     feature buffer read port (signed 16-bit data)
//   mul_din0/1, mul_dout     operands to / product from the shared multiplier
//   ap_return                signed dot product, held after ap_done
module tiled_conv_mac_seq #(
  parameter int LEN_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] base_w,
  input  logic [ADDR_WIDTH-1:0] base_x,
  output logic [ADDR_WIDTH-1:0] w_address0,
  output logic                  w_ce0,
  input  logic [15:0]           w_q0,
  output logic [ADDR_WIDTH-1:0] x_address0,
  output logic                  x_ce0,
  input  logic [15:0]           x_q0,
  output logic [15:0]           mul_din0,
  output logic [15:0]           mul_din1,
  input  logic [27:0]           mul_dout,
  output logic [ACC_WIDTH-1:0]  ap_return
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic [LEN_WIDTH-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]        w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0]        x_addr_q, x_addr_d;
  logic                         ce_q, ce_d;
  logic                         rv_q, rv_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  ret_q, ret_d;
  logic                         done_q, done_d;
  logic                         idle_q, idle_d;

  // Sign-extend the 28-bit product to the accumulator width.
  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [27:0] p);
    sext_prod = ACC_WIDTH'(p);
  endfunction

  // Accumulation wraps modulo 2^ACC_WIDTH; there is deliberately no saturation.
  function automatic logic signed [ACC_WIDTH-1:0] wrap_add(input logic signed [ACC_WIDTH-1:0] a,
                                                           input logic signed [ACC_WIDTH-1:0] b);
    wrap_add = a + b;
  endfunction

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    w_addr_d = w_addr_q;
    x_addr_d = x_addr_q;
    ce_d     = ce_q;
    acc_d    = acc_q;

    // rv_q marks the cycle in which read data from the previous cycle is valid.
    if (rv_q) begin
      acc_d = wrap_add(acc_q, sext_prod(mul_dout));
    end

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          len_d    = len;
          idx_d    = '0;
          acc_d    = '0;
          w_addr_d = base_w;
          x_addr_d = base_x;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            ce_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Addresses are kept as running base+idx values, so wrap is implicit.
        if (idx_q == len_q - LEN_WIDTH'(1)) begin
          state_d = S_DRAIN;
          ce_d    = 1'b0;
        end else begin
          idx_d    = idx_q + LEN_WIDTH'(1);
          w_addr_d = w_addr_q + ADDR_WIDTH'(1);
          x_addr_d = x_addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rv_d   = (state_q == S_RUN);
    idle_d = (state_d == S_IDLE);
    done_d = (state_d == S_DONE);
    // acc_d already contains the final product when DONE is entered.
    ret_d  = (state_d == S_DONE && state_q != S_DONE) ? acc_d : ret_q;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      w_addr_q <= '0;
      x_addr_q <= '0;
      ce_q     <= 1'b0;
      rv_q     <= 1'b0;
      acc_q    <= '0;
      ret_q    <= '0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      w_addr_q <= w_addr_d;
      x_addr_q <= x_addr_d;
      ce_q     <= ce_d;
      rv_q     <= rv_d;
      acc_q    <= acc_d;
      ret_q    <= ret_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
    end
  end

  assign w_address0 = w_addr_q;
  assign x_address0 = x_addr_q;
  assign w_ce0      = ce_q;
  assign x_ce0      = ce_q;
  assign mul_din0   = rv_q ? w_q0 : 16'd0;
  assign mul_din1   = rv_q ? x_q0 : 16'd0;
  assign ap_done    = done_q;
  assign ap_ready   = done_q;
  assign ap_idle    = idle_q;
  assign ap_return  = ret_q;

endmodule
